// File: rtl/mac_simd_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mac_simd_pipe_if                                                |
// | Purpose  : Operand/result stream bundle for mac_simd_pipe (out_ovf present |
// |            only when MAC_SAT_EN is defined).                               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface mac_simd_pipe_if #(
  parameter int BW    = 8,
  parameter int LANES = 4,
  parameter int GUARD = 4
);
  localparam int ACC_W = 2*BW + GUARD;

  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*BW-1:0]    in_a;
  logic [LANES*BW-1:0]    in_b;
  logic [LANES*ACC_W-1:0] in_c;
  logic                   in_first;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*ACC_W-1:0] out_c;
  logic                   busy;
`ifdef MAC_SAT_EN
  logic [LANES-1:0]       out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_c, in_first, in_last, out_ready,
    input  in_ready, out_valid, out_c, busy, out_ovf
  );
  modport slave (
    input  in_valid, in_a, in_b, in_c, in_first, in_last, out_ready,
    output in_ready, out_valid, out_c, busy, out_ovf
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_c, in_first, in_last, out_ready,
    input  in_ready, out_valid, out_c, busy
  );
  modport slave (
    input  in_valid, in_a, in_b, in_c, in_first, in_last, out_ready,
    output in_ready, out_valid, out_c, busy
  );
`endif
endinterface
`default_nettype wire

// File: rtl/mac_simd_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mac_simd_pipe                                                   |
// | Purpose  : LANES-wide two-stage (multiply, accumulate) burst MAC engine.   |
// |            Define MAC_SAT_EN for saturating accumulate and out_ovf flags.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mac_simd_pipe #(
  parameter int BW     = 8,
  parameter int LANES  = 4,
  parameter int GUARD  = 4,
  parameter int SIGNED = 0
) (
  input wire             clk,
  input wire             rst,
  mac_simd_pipe_if.slave bus
);
  localparam int ACC_W = 2*BW + GUARD;
  localparam int PW    = 2*BW;

  logic                        r_s1_valid;
  logic                        r_s1_first;
  logic                        r_s1_last;
  logic [LANES-1:0][PW-1:0]    r_s1_prod;
  logic [LANES-1:0][ACC_W-1:0] r_s1_c;
  logic [LANES-1:0][ACC_W-1:0] r_acc;
  logic [LANES-1:0][ACC_W-1:0] r_out_c;
  logic                        r_out_valid;
  logic                        r_open;

  logic [LANES-1:0][PW-1:0]    w_prod;
  logic [LANES-1:0][ACC_W-1:0] w_next_acc;
  logic                        w_s1_advance;
  logic                        w_accept;

  // Only a last beat can stall, and only when its result slot is still occupied.
  assign w_s1_advance = r_s1_valid & ~(r_s1_last & r_out_valid & ~bus.out_ready);
  assign bus.in_ready = ~rst & (~r_s1_valid | w_s1_advance);
  assign w_accept     = bus.in_valid & bus.in_ready;

`ifdef MAC_SAT_EN
  logic [LANES-1:0] w_sat;
  logic [LANES-1:0] w_ovf_next;
  logic [LANES-1:0] r_ovf_run;
  logic [LANES-1:0] r_out_ovf;

  assign w_ovf_next  = r_s1_first ? w_sat : (r_ovf_run | w_sat);
  assign bus.out_ovf = r_out_ovf;
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [BW-1:0]    w_a;
    logic [BW-1:0]    w_b;
    logic [PW-1:0]    w_a_ext;
    logic [PW-1:0]    w_b_ext;
    logic [ACC_W-1:0] w_pext;
    logic [ACC_W-1:0] w_base;

    assign w_a = bus.in_a[l*BW +: BW];
    assign w_b = bus.in_b[l*BW +: BW];

    if (SIGNED != 0) begin : g_signed
      assign w_a_ext = {{BW{w_a[BW-1]}}, w_a};
      assign w_b_ext = {{BW{w_b[BW-1]}}, w_b};
      assign w_pext  = {{GUARD{r_s1_prod[l][PW-1]}}, r_s1_prod[l]};
    end else begin : g_unsigned
      assign w_a_ext = {{BW{1'b0}}, w_a};
      assign w_b_ext = {{BW{1'b0}}, w_b};
      assign w_pext  = {{GUARD{1'b0}}, r_s1_prod[l]};
    end

    // Truncated PW-bit product is exact for both encodings after extension.
    assign w_prod[l] = w_a_ext * w_b_ext;
    assign w_base    = r_s1_first ? r_s1_c[l] : r_acc[l];

`ifdef MAC_SAT_EN
    logic [ACC_W:0] w_sum;
    logic           w_ovf;
    if (SIGNED != 0) begin : g_sat_s
      assign w_sum = {w_base[ACC_W-1], w_base} + {w_pext[ACC_W-1], w_pext};
      assign w_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];
      assign w_next_acc[l] = !w_ovf        ? w_sum[ACC_W-1:0] :
                             w_sum[ACC_W]  ? {1'b1, {(ACC_W-1){1'b0}}} :
                                             {1'b0, {(ACC_W-1){1'b1}}};
    end else begin : g_sat_u
      assign w_sum = {1'b0, w_base} + {1'b0, w_pext};
      assign w_ovf = w_sum[ACC_W];
      assign w_next_acc[l] = w_ovf ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
    end
    assign w_sat[l] = w_ovf;
`else
    assign w_next_acc[l] = w_base + w_pext;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_first  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_prod   <= '0;
      r_s1_c      <= '0;
      r_acc       <= '0;
      r_out_c     <= '0;
      r_out_valid <= 1'b0;
      r_open      <= 1'b0;
`ifdef MAC_SAT_EN
      r_ovf_run   <= '0;
      r_out_ovf   <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_prod  <= w_prod;
        r_s1_c     <= bus.in_c;
        r_s1_first <= bus.in_first;
        r_s1_last  <= bus.in_last;
      end else if (w_s1_advance) begin
        r_s1_valid <= 1'b0;
      end

      if (w_s1_advance) begin
        r_acc <= w_next_acc;
`ifdef MAC_SAT_EN
        r_ovf_run <= w_ovf_next;
`endif
        if (r_s1_last) begin
          r_out_c <= w_next_acc;
          r_open  <= 1'b0;
`ifdef MAC_SAT_EN
          r_out_ovf <= w_ovf_next;
`endif
        end else if (r_s1_first) begin
          r_open <= 1'b1;
        end
      end

      if (w_s1_advance && r_s1_last) begin
        r_out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_c     = r_out_c;
  assign bus.busy      = r_s1_valid | r_out_valid | r_open;

endmodule
`default_nettype wire
